// File: rtl/prog_loader.sv
// Boot-time program loader: holds the core in reset, packs an 8-bit stream
// little-endian into RAM words written from BOOT_ADDR, then releases the core.
module prog_loader #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned WORD_WIDTH = 32,
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  run,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WORD_WIDTH-1:0] ram_wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done
);
    localparam int unsigned           BPW       = WORD_WIDTH / 8;
    localparam int unsigned           BCW       = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [ADDR_WIDTH:0]   MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] BASE      = BOOT_ADDR[ADDR_WIDTH-1:0];
    localparam logic [BCW-1:0]        LAST_BYTE = BCW'(BPW - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, FINISH, RUN} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   wc_q, wc_d;
    logic [BCW-1:0]        bc_q, bc_d;
    logic [WORD_WIDTH-1:0] buf_q, buf_d;
    logic [ADDR_WIDTH:0]   len_clamped;

    logic                  s_ready_q, s_ready_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [WORD_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    assign len_clamped = (len > MAX_WORDS) ? MAX_WORDS : len;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            wc_q        <= '0;
            bc_q        <= '0;
            buf_q       <= '0;
            s_ready_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wc_q        <= wc_d;
            bc_q        <= bc_d;
            buf_q       <= buf_d;
            s_ready_q   <= s_ready_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wc_d    = wc_q;
        bc_d    = bc_q;
        buf_d   = buf_q;
        unique case (state_q)
            IDLE, RUN: begin
                if (start) begin
                    state_d = LOAD;
                    len_d   = len_clamped;
                    wc_d    = '0;
                    bc_d    = '0;
                    buf_d   = '0;
                end else if (run && (state_q == IDLE)) begin
                    state_d = RUN;
                end
            end
            LOAD: begin
                if (len_q == '0) begin
                    state_d = FINISH;
                end else if (s_valid && s_ready_q) begin
                    buf_d[8*bc_q +: 8] = s_data;
                    bc_d               = bc_q + 1'b1;
                    if (bc_q == LAST_BYTE) state_d = WRITE;
                end
            end
            WRITE: begin
                wc_d    = wc_q + 1'b1;
                bc_d    = '0;
                state_d = (wc_d == len_q) ? FINISH : LOAD;
            end
            FINISH:  state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the next state so every port comes straight from a flop
    // yet still lines up with the state it describes.
    always_comb begin
        s_ready_d   = (state_d == LOAD) && (len_d != '0);
        ram_we_d    = (state_d == WRITE);
        ram_addr_d  = ram_we_d ? (BASE + wc_q[ADDR_WIDTH-1:0]) : ram_addr_q;
        ram_wdata_d = ram_we_d ? buf_d : ram_wdata_q;
        cpu_rst_d   = (state_d != RUN);
        busy_d      = (state_d == LOAD) || (state_d == WRITE);
        done_d      = (state_d == FINISH);
    end

    assign s_ready   = s_ready_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two instances (boot address 0 and 0x1FE)
// share stimulus; a word-level scoreboard checks every RAM write.
module tb_prog_loader;
    localparam int AW = 9;
    localparam int WW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, run, s_valid;
    logic [AW:0]   len;
    logic [7:0]    s_data;
    logic          s_ready0, ram_we0, cpu_rst0, busy0, done0;
    logic [AW-1:0] ram_addr0;
    logic [WW-1:0] ram_wdata0;
    logic          s_ready1, ram_we1, cpu_rst1, busy1, done1;
    logic [AW-1:0] ram_addr1;
    logic [WW-1:0] ram_wdata1;

    prog_loader #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .BOOT_ADDR(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst), .start(start), .run(run), .len(len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready0),
        .ram_we(ram_we0), .ram_addr(ram_addr0), .ram_wdata(ram_wdata0),
        .cpu_rst(cpu_rst0), .busy(busy0), .done(done0));

    prog_loader #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .BOOT_ADDR(32'h0000_01FE)) dut1 (
        .clk(clk), .rst(rst), .start(start), .run(run), .len(len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready1),
        .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
        .cpu_rst(cpu_rst1), .busy(busy1), .done(done1));

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc   = 0;

    logic [7:0]    stim [0:2047];
    logic [AW-1:0] exp_a0 [$];
    logic [AW-1:0] exp_a1 [$];
    logic [WW-1:0] exp_d0 [$];
    logic [WW-1:0] exp_d1 [$];
    logic [AW-1:0] log_a0 [$];
    logic [AW-1:0] log_a1 [$];
    logic [WW-1:0] log_d0 [$];
    int unsigned   wr_cyc [$];
    int unsigned   done_cyc [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic bad(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: RAM write with no expected word pending (cycle %0d)", nm, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every write from either instance must match the next packed word.
    always @(negedge clk) begin
        if (ram_we0) begin
            wr_cyc.push_back(cyc);
            log_a0.push_back(ram_addr0);
            log_d0.push_back(ram_wdata0);
            chk("s_ready_in_write0", s_ready0, 1'b0);
            chk("busy_in_write0", busy0, 1'b1);
            if (exp_a0.size() == 0) bad("wr_extra0");
            else begin
                chk("wr_addr0", ram_addr0, exp_a0.pop_front());
                chk("wr_data0", ram_wdata0, exp_d0.pop_front());
            end
        end
        if (ram_we1) begin
            log_a1.push_back(ram_addr1);
            chk("s_ready_in_write1", s_ready1, 1'b0);
            if (exp_a1.size() == 0) bad("wr_extra1");
            else begin
                chk("wr_addr1", ram_addr1, exp_a1.pop_front());
                chk("wr_data1", ram_wdata1, exp_d1.pop_front());
            end
        end
        if (done0) begin
            done_cyc.push_back(cyc);
            chk("busy_at_done", busy0, 1'b0);
        end
    end

    task automatic do_load(input int unsigned n_len, input int unsigned gap,
                           input int unsigned n_offer, input int unsigned abort_at,
                           input bit inject, output int unsigned ks, output int unsigned n_acc);
        int unsigned nw, idx, gc, lim;
        bit acc, seen, stop;
        nw = (n_len > 512) ? 512 : n_len;
        if (abort_at != 0) nw = abort_at / 4;
        for (int unsigned w = 0; w < nw; w++) begin
            logic [WW-1:0] word;
            for (int unsigned b = 0; b < 4; b++) word[8*b +: 8] = stim[4*w + b];
            exp_a0.push_back(AW'(w));
            exp_a1.push_back(AW'(32'h1FE + w));
            exp_d0.push_back(word);
            exp_d1.push_back(word);
        end
        ks    = cyc;
        start = 1'b1;
        len   = n_len[AW:0];
        tick();
        start = 1'b0;
        chk("cpu_rst_after_start", cpu_rst0, 1'b1);
        chk("busy_after_start", busy0, 1'b1);
        idx  = 0;
        gc   = 0;
        seen = 1'b0;
        stop = 1'b0;
        lim  = (nw + 2) * (4 * (gap + 1) + 2) + 20;
        for (int unsigned it = 0; it < lim && !seen && !stop; it++) begin
            if (inject && (it % 97 == 50)) begin
                start = 1'b1;
                len   = 1;
            end else begin
                start = 1'b0;
            end
            s_valid = (idx < n_offer) && (gc == 0);
            s_data  = (idx < 2048) ? stim[idx] : 8'h00;
            acc     = s_valid && s_ready0;
            tick();
            if (acc) begin
                idx++;
                gc = gap;
            end else if (gc > 0) begin
                gc--;
            end
            if (abort_at != 0 && idx == abort_at) stop = 1'b1;
            if (done0) seen = 1'b1;
        end
        start   = 1'b0;
        s_valid = 1'b0;
        n_acc   = idx;
        if (abort_at == 0) begin
            chk("load_finished_in_budget", seen, 1'b1);
            chk("cpu_rst_at_done", cpu_rst0, 1'b1);
            tick();
            chk("cpu_rst_after_done", cpu_rst0, 1'b0);
            chk("busy_after_done", busy0, 1'b0);
            chk("bytes_accepted", idx, nw * 4);
        end
    endtask

    int unsigned ks, na, wb, db, lb1;
    logic [7:0] basic_bytes [0:7];

    initial begin
        basic_bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        rst = 1'b0; start = 1'b0; run = 1'b0; s_valid = 1'b0; len = '0; s_data = '0;
        tick();
        tick();
        chk("rst_cpu_rst", cpu_rst0, 1'b1);
        chk("rst_s_ready", s_ready0, 1'b0);
        chk("rst_ram_we", ram_we0, 1'b0);
        chk("rst_ram_addr", ram_addr0, 0);
        chk("rst_ram_wdata", ram_wdata0, 0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        rst = 1'b1;
        tick();

        // Basic load, valid held high
        for (int i = 0; i < 8; i++) stim[i] = basic_bytes[i];
        wb = wr_cyc.size(); db = done_cyc.size(); lb1 = log_a1.size();
        do_load(2, 0, 8, 0, 1'b0, ks, na);
        chk("basic_nwrites", wr_cyc.size() - wb, 2);
        if (wr_cyc.size() >= wb + 2 && done_cyc.size() > db) begin
            chk("basic_first_write_latency", wr_cyc[wb] - ks, 5);
            chk("basic_write_spacing", wr_cyc[wb+1] - wr_cyc[wb], 5);
            chk("basic_done_after_write", done_cyc[db] - wr_cyc[wb+1], 1);
            chk("basic_word0", {log_a0[wb], log_d0[wb]}, {9'h000, 32'h1234_5678});
            chk("basic_word1", {log_a0[wb+1], log_d0[wb+1]}, {9'h001, 32'hDEAD_BEEF});
        end

        // Backpressure: 3 idle cycles between bytes, from RUN
        wb = wr_cyc.size();
        do_load(2, 3, 8, 0, 1'b0, ks, na);
        chk("bp_nwrites", wr_cyc.size() - wb, 2);
        if (wr_cyc.size() >= wb + 2) begin
            chk("bp_word0", {log_a0[wb], log_d0[wb]}, {9'h000, 32'h1234_5678});
            chk("bp_word1", {log_a0[wb+1], log_d0[wb+1]}, {9'h001, 32'hDEAD_BEEF});
        end

        // Zero length: no bytes taken, no writes
        wb = wr_cyc.size(); db = done_cyc.size();
        do_load(0, 0, 4, 0, 1'b0, ks, na);
        chk("zero_nwrites", wr_cyc.size() - wb, 0);
        if (done_cyc.size() > db) chk("zero_done_latency", done_cyc[db] - ks, 2);
        else chk("zero_done_seen", done_cyc.size() - db, 1);

        // Run from IDLE
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        wb  = wr_cyc.size();
        run = 1'b1;
        chk("run_idle_cpu_rst_before", cpu_rst0, 1'b1);
        tick();
        run = 1'b0;
        chk("run_idle_cpu_rst_after", cpu_rst0, 1'b0);
        tick();
        chk("run_idle_still_running", cpu_rst0, 1'b0);
        chk("run_idle_nwrites", wr_cyc.size() - wb, 0);

        // Reload from RUN, length clamped to 512, stray start pulses ignored
        for (int i = 0; i < 2048; i++) stim[i] = 8'(i * 7 + 3);
        wb = wr_cyc.size(); db = done_cyc.size(); lb1 = log_a1.size();
        do_load(600, 0, 2048, 0, 1'b1, ks, na);
        chk("clamp_nwrites", wr_cyc.size() - wb, 512);
        chk("clamp_ndone", done_cyc.size() - db, 1);
        if (wr_cyc.size() >= wb + 512 && log_a1.size() >= lb1 + 512) begin
            chk("clamp_first_addr", log_a0[wb], 9'h000);
            chk("clamp_last_addr", log_a0[wb+511], 9'h1FF);
            chk("clamp_first_word", log_d0[wb], 32'h18_11_0A_03);
            chk("clamp_boot_wrap_addr", {log_a1[lb1], log_a1[lb1+2]}, {9'h1FE, 9'h000});
        end

        // Reset mid-load after 6 bytes, then a clean single-word load
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) stim[i] = 8'hA0 + 8'(i);
        wb = wr_cyc.size();
        do_load(4, 0, 8, 6, 1'b0, ks, na);
        chk("abort_bytes_taken", na, 6);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("abort_cpu_rst", cpu_rst0, 1'b1);
        chk("abort_busy", busy0, 1'b0);
        chk("abort_s_ready", s_ready0, 1'b0);
        tick();
        chk("abort_nwrites", wr_cyc.size() - wb, 1);
        stim[0] = 8'h01; stim[1] = 8'h02; stim[2] = 8'h03; stim[3] = 8'h04;
        wb = wr_cyc.size();
        do_load(1, 0, 4, 0, 1'b0, ks, na);
        chk("fresh_nwrites", wr_cyc.size() - wb, 1);
        if (wr_cyc.size() > wb) chk("fresh_word", {log_a0[wb], log_d0[wb]}, {9'h000, 32'h0403_0201});

        // Address wrap on the BOOT_ADDR=0x1FE instance
        lb1 = log_a1.size();
        do_load(4, 0, 16, 0, 1'b0, ks, na);
        chk("wrap_nwrites", log_a1.size() - lb1, 4);
        if (log_a1.size() >= lb1 + 4)
            chk("wrap_addrs", {log_a1[lb1], log_a1[lb1+1], log_a1[lb1+2], log_a1[lb1+3]},
                {9'h1FE, 9'h1FF, 9'h000, 9'h001});

        tick();
        chk("exp_drained0", exp_a0.size(), 0);
        chk("exp_drained1", exp_a1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time sequencer for the instruction RAM and fetch stage.
- Holds the CPU core in reset, accepts a byte stream from the host interface, packs the bytes into words and writes them into program RAM starting at BOOT_ADDR.
- Releases the core to run once the load is complete.
- Sits between the host/UART receive path and the program RAM write port. It drives the core reset that fetch samples.

Parameters:
- ADDR_WIDTH, 9: program RAM word-address width.
- WORD_WIDTH, 32: RAM word width. Must be a multiple of 8. BPW = WORD_WIDTH/8 bytes per word.
- BOOT_ADDR, 32'h00000000: first RAM word address written. Low ADDR_WIDTH bits are used.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: synchronous, active-low reset.
- start, input, 1: single-cycle request to begin a load.
- run, input, 1: single-cycle request to release the core without loading.
- len, input, ADDR_WIDTH+1: number of words to load. Sampled on start.
- s_data, input, 8: stream byte.
- s_valid, input, 1: s_data is valid.
- s_ready, output, 1: loader accepts s_data this cycle.
- ram_we, output, 1: RAM write strobe.
- ram_addr, output, ADDR_WIDTH: RAM write word address.
- ram_wdata, output, WORD_WIDTH: RAM write data.
- cpu_rst, output, 1: active-high reset to the core/fetch stage.
- busy, output, 1: load in progress.
- done, output, 1: one-cycle pulse when a load completes.

Behaviour:
- All outputs are registered.
- Reset values (rst=0 at a clock edge): state IDLE, cpu_rst=1, s_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, busy=0, done=0. All counters and partial words are cleared.
- Reset mid-load discards any partial word and writes nothing further.
- States: IDLE, LOAD, WRITE, FINISH, RUN.
- IDLE:
  - cpu_rst=1.
  - start → LOAD. Latch len_q = min(len, 2^ADDR_WIDTH); clear word count wc=0 and byte count bc=0.
  - run (without start) → RUN.
  - start and run asserted together: start wins.
- LOAD:
  - busy=1, s_ready=1.
  - A byte is accepted when s_valid && s_ready. It goes to bits [8*bc+7 : 8*bc] of the word buffer (little-endian, first byte is the LSB); bc increments.
  - When the accepted byte has bc==BPW-1 → WRITE, and s_ready drops the following cycle.
  - Cycles with s_valid=0 are stalls; nothing changes.
- WRITE:
  - Exactly one cycle. ram_we=1, ram_addr=BOOT_ADDR[ADDR_WIDTH-1:0]+wc (modulo 2^ADDR_WIDTH, wraps), ram_wdata=word buffer, s_ready=0.
  - wc increments and bc clears.
  - If the new wc==len_q → FINISH; otherwise → LOAD.
- FINISH:
  - One cycle. done=1, busy=0. Next state RUN.
- len=0 on start: LOAD → FINISH directly, with no stream bytes accepted and no RAM write.
- RUN:
  - cpu_rst=0 from the first RUN cycle.
  - start → LOAD. cpu_rst=1 is registered in that same transition, so the core is in reset before the first write. len is latched as in IDLE.
  - run in RUN is ignored.
- start while busy (LOAD/WRITE/FINISH) is ignored.
- Throughput: minimum BPW+1 cycles per word (BPW accept cycles plus 1 write cycle).
- cpu_rst deasserts on the cycle after the done pulse.
- The byte counter is log2(BPW) bits. The word counter is ADDR_WIDTH+1 bits, so a full 2^ADDR_WIDTH-word load terminates correctly.

Test Plan:
- Basic load: reset, start with len=2, stream 78 56 34 12 EF BE AD DE with s_valid held high → writes addr0=0x12345678 then addr1=0xDEADBEEF. Each ram_we lasts one cycle, 5 cycles apart. done pulses 1 cycle after the second write; cpu_rst=0 on the following cycle.
- Backpressure: same stream as the basic load, with s_valid low for 3 cycles between every byte → identical writes and data; no byte is lost or duplicated; s_ready=0 during WRITE.
- Zero length and run path:
  - start with len=0 → no ram_we, done pulses 2 cycles after start, then cpu_rst=0.
  - Separately, run from IDLE → cpu_rst=0 one cycle later, no writes.
- Reset mid-load: start len=4, drive rst=0 after 6 bytes → next cycle cpu_rst=1, busy=0, s_ready=0. A new start with len=1 and bytes 01 02 03 04 → single write addr0=0x04030201, with no leftover bytes from the aborted load.
- Reload from RUN and clamp, with ADDR_WIDTH=9:
  - From RUN, start with len=600 → cpu_rst=1 immediately; exactly 512 writes to addresses 0..511; done pulses once.
  - start pulses during LOAD are ignored.
- Address wrap: BOOT_ADDR=32'h1FE, len=4 → writes to addresses 0x1FE, 0x1FF, 0x000, 0x001.
